// File: rtl/pingpong_trans_ctrl.sv
// pingpong_trans_ctrl: ping-pong bank controller turning a row-major matrix stream into a column-major one
module pingpong_trans_ctrl #(
  parameter int LOG2N = 3,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 2*LOG2N
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  output logic                  ram0_en,
  output logic                  ram1_en,
  output logic                  ram0_we,
  output logic                  ram1_we,
  output logic [ADDR_WIDTH-1:0] ram0_addr,
  output logic [ADDR_WIDTH-1:0] ram1_addr,
  output logic [DATA_WIDTH-1:0] ram0_din,
  output logic [DATA_WIDTH-1:0] ram1_din,
  input  logic [DATA_WIDTH-1:0] ram0_dout,
  input  logic [DATA_WIDTH-1:0] ram1_dout
);
  typedef enum logic [1:0] {EMPTY, FILLING, FULL, DRAINING} bank_t;
  bank_t st [2];
  bank_t st_n [2];
  logic wsel, rsel, wr, rd, pop, inflight, rd_bank, rd_last, rp, wp;
  logic [ADDR_WIDTH-1:0] wcnt, rcnt, raddr;
  logic [DATA_WIDTH-1:0] fd [2];
  logic [DATA_WIDTH-1:0] dout;
  logic fl [2];
  logic [1:0] occ;
  // bank state registers
  always_ff @(posedge clk)
    if (rst) begin
      st[0] <= EMPTY;
      st[1] <= EMPTY;
    end else st <= st_n;
  // a bank is written or read in a cycle, never both, so one event decides its next state
  always_comb begin
    st_n = st;
    for (int b = 0; b < 2; b++) begin
      if (wr && wsel == 1'(b)) st_n[b] = (wcnt == '1) ? FULL : FILLING;
      if (rd && rsel == 1'(b)) st_n[b] = (rcnt == '1) ? EMPTY : DRAINING;
    end
  end
  // handshakes, read issue and bank port steering
  always_comb begin
    s_ready = !rst && (st[wsel] == EMPTY || st[wsel] == FILLING);
    wr = s_valid && s_ready;
    m_valid = !rst && occ != 2'd0;
    m_data = rst ? '0 : fd[rp];
    m_last = m_valid && fl[rp];
    pop = m_valid && m_ready;
    rd = !rst && (st[rsel] == FULL || st[rsel] == DRAINING) && ({1'b0, occ} + 3'(inflight) < 3'd2 + 3'(pop));
    raddr = {rcnt[LOG2N-1:0], rcnt[2*LOG2N-1:LOG2N]};
    ram0_we = wr && !wsel;
    ram1_we = wr && wsel;
    ram0_en = ram0_we || (rd && !rsel);
    ram1_en = ram1_we || (rd && rsel);
    ram0_addr = ram0_we ? wcnt : raddr;
    ram1_addr = ram1_we ? wcnt : raddr;
    ram0_din = s_data;
    ram1_din = s_data;
    dout = rd_bank ? ram1_dout : ram0_dout;
  end
  // counters, bank pointers, in-flight read tracking and the 2-entry output buffer
  always_ff @(posedge clk)
    if (rst) begin
      wsel <= 1'b0;
      rsel <= 1'b0;
      wcnt <= '0;
      rcnt <= '0;
      inflight <= 1'b0;
      rd_bank <= 1'b0;
      rd_last <= 1'b0;
      rp <= 1'b0;
      wp <= 1'b0;
      occ <= 2'd0;
      fd[0] <= '0;
      fd[1] <= '0;
      fl[0] <= 1'b0;
      fl[1] <= 1'b0;
    end else begin
      if (wr) begin
        wcnt <= wcnt + 1'b1;
        wsel <= (wcnt == '1) ? ~wsel : wsel;
      end
      if (rd) begin
        rcnt <= rcnt + 1'b1;
        rsel <= (rcnt == '1) ? ~rsel : rsel;
      end
      inflight <= rd;
      rd_bank <= rsel;
      rd_last <= rcnt == '1;
      if (inflight) begin
        fd[wp] <= dout;
        fl[wp] <= rd_last;
        wp <= ~wp;
      end
      if (pop) rp <= ~rp;
      occ <= occ + 2'(inflight) - 2'(pop);
    end
endmodule

// File: tb/tb_pingpong_trans_ctrl.sv
// tb_pingpong_trans_ctrl: randomized scoreboard bench for the ping-pong transpose controller
module tb_pingpong_trans_ctrl;
  localparam int N = 8;
  localparam int NN = N*N;
  logic clk = 0;
  logic rst = 1;
  logic s_valid = 0, m_ready = 0;
  logic [31:0] s_data = 0;
  logic s_ready, m_valid, m_last;
  logic [31:0] m_data;
  logic ram0_en, ram1_en, ram0_we, ram1_we;
  logic [5:0] ram0_addr, ram1_addr;
  logic [31:0] ram0_din, ram1_din;
  logic [31:0] ram0_dout = 0, ram1_dout = 0;
  logic [31:0] mem0 [NN];
  logic [31:0] mem1 [NN];
  logic s2_valid = 0, m2_ready = 1;
  logic [7:0] s2_data = 0;
  logic s2_ready, m2_valid, m2_last;
  logic [7:0] m2_data;
  logic r20_en, r21_en, r20_we, r21_we;
  logic [1:0] r20_addr, r21_addr;
  logic [7:0] r20_din, r21_din;
  logic [7:0] r20_dout = 0, r21_dout = 0;
  logic [7:0] m20 [4];
  logic [7:0] m21 [4];
  int vectors = 0, miscompares = 0;
  int cyc = 0, out_cnt = 0, last_cnt = 0, mats = 0, last_hs_cyc = 0;
  bit rand_ready = 0;
  bit pmv = 0, pmr = 0, pml = 0;
  logic [31:0] pmd = 0;
  logic [31:0] in_q [$];
  logic [31:0] exp_d [$];
  bit exp_l [$];

  pingpong_trans_ctrl #(.LOG2N(3), .DATA_WIDTH(32), .ADDR_WIDTH(6)) dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .ram0_en(ram0_en), .ram1_en(ram1_en), .ram0_we(ram0_we), .ram1_we(ram1_we),
    .ram0_addr(ram0_addr), .ram1_addr(ram1_addr), .ram0_din(ram0_din), .ram1_din(ram1_din),
    .ram0_dout(ram0_dout), .ram1_dout(ram1_dout));

  pingpong_trans_ctrl #(.LOG2N(1), .DATA_WIDTH(8), .ADDR_WIDTH(2)) dut2 (
    .clk(clk), .rst(rst), .s_valid(s2_valid), .s_ready(s2_ready), .s_data(s2_data),
    .m_valid(m2_valid), .m_ready(m2_ready), .m_data(m2_data), .m_last(m2_last),
    .ram0_en(r20_en), .ram1_en(r21_en), .ram0_we(r20_we), .ram1_we(r21_we),
    .ram0_addr(r20_addr), .ram1_addr(r21_addr), .ram0_din(r20_din), .ram1_din(r21_din),
    .ram0_dout(r20_dout), .ram1_dout(r21_dout));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (ram0_en) begin if (ram0_we) mem0[ram0_addr] <= ram0_din; else ram0_dout <= mem0[ram0_addr]; end
    if (ram1_en) begin if (ram1_we) mem1[ram1_addr] <= ram1_din; else ram1_dout <= mem1[ram1_addr]; end
    if (r20_en) begin if (r20_we) m20[r20_addr] <= r20_din; else r20_dout <= m20[r20_addr]; end
    if (r21_en) begin if (r21_we) m21[r21_addr] <= r21_din; else r21_dout <= m21[r21_addr]; end
  end

  initial forever begin
    @(posedge clk); #1;
    if (rand_ready) m_ready = 1'($urandom % 2);
  end

  always @(negedge clk) begin
    if (rst) begin
      in_q.delete(); exp_d.delete(); exp_l.delete();
      mats = 0; pmv = 0;
    end else begin
      if (pmv && !pmr) begin
        vectors++;
        if (m_valid !== 1'b1 || m_data !== pmd || m_last !== pml) begin
          miscompares++;
          $display("FAIL hold: got v=%b d=%h l=%b, required v=1 d=%h l=%b", m_valid, m_data, m_last, pmd, pml);
        end
      end
      if (s_valid && s_ready) begin
        vectors++;
        if ((mats % 2 == 0) ? !(ram0_en && ram0_we && !ram1_we && ram0_addr == 6'(in_q.size()) && ram0_din == s_data)
                            : !(ram1_en && ram1_we && !ram0_we && ram1_addr == 6'(in_q.size()) && ram1_din == s_data)) begin
          miscompares++;
          $display("FAIL write_port: we0=%b we1=%b a0=%0d a1=%0d, required bank %0d addr %0d", ram0_we, ram1_we, ram0_addr, ram1_addr, mats % 2, in_q.size());
        end
        in_q.push_back(s_data);
        if (in_q.size() == NN) begin
          for (int k = 0; k < NN; k++) begin
            exp_d.push_back(in_q[(k % N) * N + k / N]);
            exp_l.push_back(k == NN - 1);
          end
          in_q.delete();
          mats++;
        end
      end else if (ram0_we || ram1_we) begin
        vectors++; miscompares++;
        $display("FAIL spurious_write: we0=%b we1=%b, required 0 0", ram0_we, ram1_we);
      end
      if (m_valid && m_ready) begin
        vectors++; out_cnt++;
        if (m_last) last_cnt++;
        if (exp_d.size() == 0) begin
          miscompares++;
          $display("FAIL extra_output: got %h, required none", m_data);
        end else begin
          if (m_data !== exp_d[0] || m_last !== exp_l[0]) begin
            miscompares++;
            $display("FAIL out_data: got %h last=%b, required %h last=%b", m_data, m_last, exp_d[0], exp_l[0]);
          end
          void'(exp_d.pop_front()); void'(exp_l.pop_front());
        end
      end
      pmv = m_valid; pmr = m_ready; pmd = m_data; pml = m_last;
    end
  end

  task automatic do_reset();
    rst = 1; s_valid = 0; rand_ready = 0; m_ready = 0;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    out_cnt = 0; last_cnt = 0;
  endtask

  task automatic feed(input int count, input int base, input bit rnd_v, input bit chk_ready, input int budget);
    int i = 0, g = 0;
    bit hs;
    while (i < count && g < budget) begin
      s_valid = rnd_v ? 1'($urandom % 2) : 1'b1;
      s_data = rnd_v ? $urandom : 32'(base + i);
      @(negedge clk);
      hs = s_valid && s_ready;
      if (hs) last_hs_cyc = cyc;
      if (chk_ready) begin
        vectors++;
        if (!s_ready) begin miscompares++; $display("FAIL b2b_s_ready: got 0, required 1 at elem %0d", i); end
      end
      if (hs) i++;
      g++;
      @(posedge clk); #1;
    end
    s_valid = 0;
    vectors++;
    if (i < count) begin miscompares++; $display("FAIL feed_timeout: got %0d accepted, required %0d", i, count); end
  endtask

  task automatic drain(input int budget);
    int g = 0;
    while ((exp_d.size() > 0 || m_valid) && g < budget) begin
      @(posedge clk); #1; g++;
    end
    vectors++;
    if (g >= budget) begin miscompares++; $display("FAIL drain_timeout: got %0d pending, required 0", exp_d.size()); end
  endtask

  task automatic test_reset();
    rst = 1; s_valid = 1; m_ready = 1;
    @(negedge clk);
    vectors++;
    if (s_ready !== 0 || m_valid !== 0 || m_last !== 0 || m_data !== 0 || ram0_en !== 0 || ram1_en !== 0 || ram0_we !== 0 || ram1_we !== 0) begin
      miscompares++;
      $display("FAIL reset_outputs: got sr=%b mv=%b ml=%b md=%h en=%b%b we=%b%b, required all 0", s_ready, m_valid, m_last, m_data, ram0_en, ram1_en, ram0_we, ram1_we);
    end
    @(posedge clk); #1;
    rst = 0; s_valid = 0;
    @(negedge clk);
    vectors++;
    if (s_ready !== 1 || m_valid !== 0) begin
      miscompares++;
      $display("FAIL after_reset: got sr=%b mv=%b, required sr=1 mv=0", s_ready, m_valid);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_single();
    int g = 0;
    do_reset();
    m_ready = 1;
    feed(NN, 0, 0, 0, 200);
    @(negedge clk);
    while (!m_valid && g < 10) begin @(negedge clk); g++; end
    vectors++;
    if (cyc - last_hs_cyc != 3) begin miscompares++; $display("FAIL latency: got %0d, required 3", cyc - last_hs_cyc); end
    @(posedge clk); #1;
    drain(300);
    vectors++;
    if (out_cnt != NN || last_cnt != 1) begin miscompares++; $display("FAIL single_counts: got %0d/%0d, required %0d/1", out_cnt, last_cnt, NN); end
  endtask

  task automatic test_back_to_back();
    int g = 0;
    bit started = 0;
    do_reset();
    m_ready = 1;
    feed(3*NN, 0, 0, 1, 400);
    while (out_cnt < 3*NN && g < 400) begin
      @(negedge clk);
      if (m_valid) started = 1;
      if (started && out_cnt < 3*NN) begin
        vectors++;
        if (!m_valid) begin miscompares++; $display("FAIL b2b_gap: got m_valid=0, required 1 at out %0d", out_cnt); end
      end
      @(posedge clk); #1; g++;
    end
    drain(100);
    vectors++;
    if (out_cnt != 3*NN || last_cnt != 3) begin miscompares++; $display("FAIL b2b_counts: got %0d/%0d, required %0d/3", out_cnt, last_cnt, 3*NN); end
  endtask

  task automatic test_stall();
    int acc = 0;
    do_reset();
    m_ready = 0;
    for (int g = 0; g < 300; g++) begin
      s_valid = 1; s_data = 32'(acc);
      @(negedge clk);
      if (s_valid && s_ready) acc++;
      @(posedge clk); #1;
    end
    @(negedge clk);
    vectors++;
    if (acc != 2*NN || s_ready !== 0 || m_valid !== 1 || m_data !== 0 || m_last !== 0) begin
      miscompares++;
      $display("FAIL stall: got acc=%0d sr=%b mv=%b md=%h, required acc=%0d sr=0 mv=1 md=0", acc, s_ready, m_valid, m_data, 2*NN);
    end
    @(posedge clk); #1;
    s_valid = 0; m_ready = 1;
    drain(400);
    vectors++;
    if (out_cnt != 2*NN || last_cnt != 2) begin miscompares++; $display("FAIL stall_counts: got %0d/%0d, required %0d/2", out_cnt, last_cnt, 2*NN); end
  endtask

  task automatic test_random();
    do_reset();
    rand_ready = 1;
    feed(5*NN, 0, 1, 0, 5000);
    drain(5000);
    rand_ready = 0; m_ready = 1;
    drain(200);
    vectors++;
    if (out_cnt != 5*NN || last_cnt != 5) begin miscompares++; $display("FAIL random_counts: got %0d/%0d, required %0d/5", out_cnt, last_cnt, 5*NN); end
  endtask

  task automatic test_reset_mid();
    int i = 0, g = 0;
    do_reset();
    m_ready = 1;
    while (out_cnt < 20 && g < 500) begin
      s_valid = 1; s_data = 32'(i);
      @(negedge clk);
      if (s_valid && s_ready) i++;
      @(posedge clk); #1; g++;
    end
    rst = 1;
    @(negedge clk);
    vectors++;
    if (m_valid !== 0 || s_ready !== 0) begin miscompares++; $display("FAIL mid_reset: got mv=%b sr=%b, required 0 0", m_valid, s_ready); end
    @(posedge clk); #1;
    rst = 0; s_valid = 0;
    @(negedge clk);
    vectors++;
    if (m_valid !== 0 || s_ready !== 1) begin miscompares++; $display("FAIL post_mid_reset: got mv=%b sr=%b, required 0 1", m_valid, s_ready); end
    @(posedge clk); #1;
    out_cnt = 0; last_cnt = 0;
    feed(NN, 1000, 0, 0, 200);
    drain(300);
    vectors++;
    if (out_cnt != NN || last_cnt != 1) begin miscompares++; $display("FAIL fresh_counts: got %0d/%0d, required %0d/1", out_cnt, last_cnt, NN); end
  endtask

  task automatic test_n2();
    logic [7:0] v [4];
    logic [7:0] got [4];
    bit gl [4];
    int i = 0, n = 0, g = 0;
    do_reset();
    for (int k = 0; k < 4; k++) v[k] = 8'($urandom);
    m2_ready = 1;
    while (n < 4 && g < 40) begin
      s2_valid = i < 4; s2_data = v[i % 4];
      @(negedge clk);
      if (s2_valid && s2_ready) i++;
      if (m2_valid && m2_ready) begin got[n] = m2_data; gl[n] = m2_last; n++; end
      @(posedge clk); #1; g++;
    end
    s2_valid = 0;
    vectors++;
    if (n != 4 || got[0] !== v[0] || got[1] !== v[2] || got[2] !== v[1] || got[3] !== v[3] || {gl[0], gl[1], gl[2], gl[3]} != 4'b0001) begin
      miscompares++;
      $display("FAIL n2: got n=%0d %h %h %h %h last=%b%b%b%b, required %h %h %h %h last=0001", n, got[0], got[1], got[2], got[3], gl[0], gl[1], gl[2], gl[3], v[0], v[2], v[1], v[3]);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_stall();
    test_random();
    test_reset_mid();
    test_n2();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
